// File: rtl/r_cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the R-type datapath: owns PC, IR and the retired counter.
// Optional build macro OVF_TRAP_EN: add/sub overflow blocks writeback and parks the core in HALT until reset.
module r_cpu_seq_ctrl #(
    parameter int              PC_W   = 32,
    parameter logic [PC_W-1:0] PC_RST = {PC_W{1'b0}},
    parameter int              CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [4:0]       rf_raddr1,
    output logic [4:0]       rf_raddr2,
    output logic             ab_we,
    output logic [2:0]       alu_op,
    input  logic             alu_of,
    output logic             res_we,
    output logic [4:0]       rf_waddr,
    output logic             rf_we,
    input  logic             halt_req,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    // Returns {supported, alu code}; anything other than the listed R-type funcs is unsupported.
    function automatic logic [3:0] decode_alu(input logic [5:0] op, input logic [5:0] func);
        logic [3:0] res;
        res = 4'b0000;
        if (op == 6'b000000) begin
            case (func)
                6'b100000: res = 4'b1100;
                6'b100010: res = 4'b1101;
                6'b100100: res = 4'b1000;
                6'b100101: res = 4'b1001;
                6'b100110: res = 4'b1010;
                6'b100111: res = 4'b1011;
                6'b101011: res = 4'b1110;
                6'b000100: res = 4'b1111;
                6'b000000: res = 4'b1000;
                default:   res = 4'b0000;
            endcase
        end else begin
            res = 4'b0000;
        end
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [PC_W-1:0]  pc_r;
    logic [31:0]      ir_r;
    logic [2:0]       alu_op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       dec_s;
    logic             trap_s;
    logic             unused_ok_s;

    assign dec_s       = decode_alu(ir_r[31:26], ir_r[5:0]);
    assign unused_ok_s = ^{ir_r[10:6], alu_of};

`ifdef OVF_TRAP_EN
    logic trap_r;

    // Signed overflow on add/sub latches a trap that only reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_r <= 1'b0;
        end else if (state_r == S_EXEC && alu_of &&
                     (alu_op_r == 3'b100 || alu_op_r == 3'b101)) begin
            trap_r <= 1'b1;
        end
    end

    assign trap_s = trap_r;
`else
    assign trap_s = 1'b0;
`endif

    // Next-state logic; boundary check happens on WB exit and on an unsupported DECODE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (imem_ready) state_nxt_s = S_DECODE;
                else            state_nxt_s = S_FETCH;
            end
            S_DECODE: begin
                if (dec_s[3])                 state_nxt_s = S_EXEC;
                else if (halt_req || trap_s)  state_nxt_s = S_HALT;
                else                          state_nxt_s = S_FETCH;
            end
            S_EXEC:  state_nxt_s = S_WB;
            S_WB: begin
                if (halt_req || trap_s) state_nxt_s = S_HALT;
                else                    state_nxt_s = S_FETCH;
            end
            S_HALT: begin
                if (halt_req || trap_s) state_nxt_s = S_HALT;
                else                    state_nxt_s = S_FETCH;
            end
            default: state_nxt_s = S_FETCH;
        endcase
    end

    // State, PC, IR, ALU code and retired counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_FETCH;
            pc_r     <= PC_RST;
            ir_r     <= 32'h0000_0000;
            alu_op_r <= 3'b000;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_FETCH && imem_ready) begin
                ir_r <= imem_rdata;
                pc_r <= pc_r + {{(PC_W-3){1'b0}}, 3'b100};
            end
            if (state_r == S_DECODE && dec_s[3]) begin
                alu_op_r <= dec_s[2:0];
            end
            if (state_r == S_WB && !trap_s) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Request is masked while reset is held so a fetch is never presented during reset.
    assign imem_req    = (state_r == S_FETCH) && !rst;
    assign imem_addr   = pc_r;
    assign rf_raddr1   = ir_r[25:21];
    assign rf_raddr2   = ir_r[20:16];
    assign rf_waddr    = ir_r[15:11];
    assign ab_we       = (state_r == S_DECODE);
    assign illegal     = (state_r == S_DECODE) && !dec_s[3];
    assign res_we      = (state_r == S_EXEC);
    assign rf_we       = (state_r == S_WB) && (ir_r[5:0] != 6'b000000) && !trap_s;
    assign halted      = (state_r == S_HALT);
    assign alu_op      = alu_op_r;
    assign state       = state_r;
    assign retired_cnt = cnt_r;

endmodule

// File: tb/tb_r_cpu_seq_ctrl.sv
// Self-checking bench for r_cpu_seq_ctrl: instruction-level reference model with random imem wait states.
module tb_r_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        ab_we, res_we, rf_we, halted, illegal;
    logic [2:0]  alu_op, state;
    logic        alu_of = 1'b0;
    logic        halt_req = 1'b0;
    logic [31:0] retired_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] exp_cnt = 32'h0;
    logic [31:0] prev_ir = 32'h0;

    logic [5:0] ref_func [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b, 6'h04, 6'h00};
    logic [2:0] ref_code [0:8] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0};

    always #5 clk = ~clk;

    r_cpu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .ab_we(ab_we), .alu_op(alu_op), .alu_of(alu_of),
        .res_we(res_we), .rf_waddr(rf_waddr), .rf_we(rf_we), .halt_req(halt_req), .halted(halted),
        .illegal(illegal), .state(state), .retired_cnt(retired_cnt)
    );

    function automatic logic [3:0] ref_decode(input logic [31:0] ins);
        if (ins[31:26] != 6'd0) return 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (ins[5:0] == ref_func[k]) return {1'b1, ref_code[k]};
        end
        return 4'd0;
    endfunction

    // One instruction from its first FETCH cycle to the first cycle after its boundary.
    task automatic run_instr(input logic [31:0] ins, input int waits, input logic ovf,
                             input logic hreq, input string tag);
        logic [3:0]   dec;
        logic         trap;
        logic         stop;
        logic [127:0] got, want;
        dec  = ref_decode(ins);
        trap = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            got  = {imem_req, imem_addr, state, ab_we, res_we, rf_we, halted, illegal,
                    rf_raddr1, rf_raddr2, rf_waddr};
            want = {1'b1, exp_pc, 3'd0, 5'b00000, prev_ir[25:21], prev_ir[20:16], prev_ir[15:11]};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL fetch[%s] wait %0d: got %h want %h", tag, i, got, want);
            end
            imem_ready = (i == waits);
            imem_rdata = (i == waits) ? ins : $urandom;
            @(negedge clk);
        end
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        halt_req   = hreq;
        exp_pc     = exp_pc + 32'd4;
        prev_ir    = ins;
        got  = {state, ab_we, res_we, rf_we, imem_req, illegal, rf_raddr1, rf_raddr2};
        want = {3'd1, 1'b1, 1'b0, 1'b0, 1'b0, ~dec[3], ins[25:21], ins[20:16]};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL decode[%s]: got %h want %h", tag, got, want);
        end
        @(negedge clk);
        if (dec[3]) begin
            alu_of = ovf;
            got  = {state, res_we, ab_we, rf_we, illegal, imem_req, alu_op};
            want = {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dec[2:0]};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL exec[%s]: got %h want %h", tag, got, want);
            end
            @(negedge clk);
            alu_of = 1'b0;
`ifdef OVF_TRAP_EN
            trap = ovf && (ins[5:0] == 6'h20 || ins[5:0] == 6'h22);
`endif
            got  = {state, rf_we, res_we, ab_we, illegal, rf_waddr, alu_op, retired_cnt};
            want = {3'd3, (ins[5:0] != 6'h00) && !trap, 1'b0, 1'b0, 1'b0, ins[15:11], dec[2:0], exp_cnt};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL writeback[%s]: got %h want %h", tag, got, want);
            end
            @(negedge clk);
            if (!trap) exp_cnt = exp_cnt + 32'd1;
        end
        stop = hreq || trap;
        got  = {state, halted, imem_req, illegal, retired_cnt, imem_addr};
        want = {stop ? 3'd4 : 3'd0, stop, ~stop, 1'b0, exp_cnt, exp_pc};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL boundary[%s]: got %h want %h", tag, got, want);
        end
    endtask

    // Sits in HALT for some cycles with PC held, then drops halt_req and expects FETCH next cycle.
    task automatic halt_release(input int cycles);
        logic [127:0] got, want;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            got  = {state, halted, imem_req, ab_we, res_we, rf_we, illegal, imem_addr};
            want = {3'd4, 1'b1, 5'b00000, exp_pc};
            n_cmp++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL halt_hold cycle %0d: got %h want %h", i, got, want);
            end
        end
        halt_req = 1'b0;
        @(negedge clk);
        got  = {state, halted, imem_req, imem_addr};
        want = {3'd0, 1'b0, 1'b1, exp_pc};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL halt_exit: got %h want %h", got, want);
        end
    endtask

    task automatic apply_reset();
        logic [127:0] got, want;
        rst        = 1'b1;
        imem_ready = 1'b1;
        halt_req   = 1'b0;
        alu_of     = 1'b0;
        for (int i = 0; i < 2; i++) begin
            imem_rdata = $urandom;
            @(negedge clk);
            got = {imem_req, ab_we, res_we, rf_we, halted, illegal};
            n_cmp++;
            if (got !== 128'd0) begin
                n_fail++;
                $display("FAIL reset_held cycle %0d: got %h want 0", i, got);
            end
        end
        rst        = 1'b0;
        imem_ready = 1'b0;
        exp_pc     = 32'h0;
        exp_cnt    = 32'h0;
        prev_ir    = 32'h0;
        #1;
        got  = {state, imem_addr, retired_cnt, alu_op, rf_raddr1, rf_raddr2, rf_waddr, imem_req, halted};
        want = {3'd0, 32'h0, 32'h0, 3'd0, 15'd0, 1'b1, 1'b0};
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", got, want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_add();
        run_instr(32'h0022_1820, 0, 1'b0, 1'b0, "add");
        n_cmp++;
        if ({imem_addr, retired_cnt} !== {32'd4, 32'd1}) begin
            n_fail++;
            $display("FAIL add_pc_cnt: got %h/%h want 4/1", imem_addr, retired_cnt);
        end
    endtask

    task automatic test_wait();
        run_instr(32'h0085_3022, 3, 1'b0, 1'b0, "wait3");
    endtask

    task automatic test_sequence();
        logic [5:0] fn [0:7] = '{6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2b, 6'h04, 6'h00};
        logic [31:0] r;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            r = $urandom;
            run_instr({6'b0, r[25:6], fn[i]}, i % 3, 1'b0, 1'b0, "seq");
        end
        n_cmp++;
        if (retired_cnt !== 32'd8) begin
            n_fail++;
            $display("FAIL seq_count: got %0d want 8", retired_cnt);
        end
    endtask

    task automatic test_illegal();
        run_instr(32'h8C01_0000, 1, 1'b0, 1'b0, "lw_illegal");
        run_instr(32'h0022_1821, 0, 1'b0, 1'b0, "addu_illegal");
        run_instr(32'h0022_1820, 0, 1'b0, 1'b0, "after_illegal");
    endtask

    task automatic test_halt();
        run_instr(32'h0043_2024, 0, 1'b0, 1'b1, "halt_and");
        halt_release(3);
        run_instr(32'h8C01_0000, 0, 1'b0, 1'b1, "halt_illegal");
        halt_release(1);
    endtask

    task automatic test_reset_mid_fetch();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin
                n_fail++;
                $display("FAIL midfetch_req: got %h want %h", {imem_req, imem_addr}, {1'b1, exp_pc});
            end
            @(negedge clk);
        end
        apply_reset();
    endtask

    task automatic test_random();
        logic [31:0] r, ins;
        logic        ovf, hreq;
        int          k;
        for (int n = 0; n < 40; n++) begin
            r = $urandom;
            k = $urandom_range(0, 10);
            if (k == 9)       ins = {6'($urandom_range(1, 63)), r[25:0]};
            else if (k == 10) ins = {6'b0, r[25:6], 6'h21};
            else              ins = {6'b0, r[25:6], ref_func[k]};
`ifdef OVF_TRAP_EN
            ovf = 1'b0;
`else
            ovf = 1'($urandom_range(0, 1));
`endif
            hreq = ($urandom_range(0, 7) == 0);
            run_instr(ins, $urandom_range(0, 3), ovf, hreq, "rand");
            if (hreq) halt_release($urandom_range(1, 3));
        end
    endtask

    task automatic test_ovf();
        run_instr(32'h0022_1820, 0, 1'b1, 1'b0, "ovf_add");
`ifdef OVF_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({state, halted, imem_req} !== {3'd4, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL trap_hold: got %h want %h", {state, halted, imem_req}, {3'd4, 1'b1, 1'b0});
            end
        end
        apply_reset();
`else
        run_instr(32'h0022_1822, 0, 1'b1, 1'b0, "ovf_sub");
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_wait();
        test_sequence();
        test_illegal();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        test_ovf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
